// File: rtl/dsc_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dsc_mul_ctrl
// Purpose  : Job controller for the dsc_mul four-operand multiplier. It
//            accepts an operand set, clears and runs the multiplier until
//            it flags completion, captures the product, and holds it until
//            the downstream side takes it. An operand set that contains a
//            zero is answered directly with a zero product, and the
//            multiplier is never enabled for it.
// Ports    : clk, rst               clock, synchronous active-high reset
//            in_valid/in_ready      operand-set handshake
//            in_a..in_d             unsigned operands (NUM_BITS each)
//            out_valid/out_ready    result handshake
//            out_z                  product, 4*NUM_BITS wide
//            out_cycles             RUN-cycle count (CYCLE_COUNT_EN only)
//            busy                   controller is not in IDLE
//            mul_rst/mul_en         multiplier reset and enable
//            mul_a..mul_d           latched operands to the multiplier
//            mul_z/mul_ov           multiplier result and completion flag
// Options  : define CYCLE_COUNT_EN to build the cycle counter and the
//            out_cycles port.
// Revision : 1.0 - initial release
// ============================================================================
module dsc_mul_ctrl #(
    parameter int NUM_BITS  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_BITS-1:0]   in_a,
    input  logic [NUM_BITS-1:0]   in_b,
    input  logic [NUM_BITS-1:0]   in_c,
    input  logic [NUM_BITS-1:0]   in_d,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NUM_BITS-1:0] out_z,
`ifdef CYCLE_COUNT_EN
    output logic [CNT_WIDTH-1:0]  out_cycles,
`endif
    output logic                  busy,
    output logic                  mul_rst,
    output logic                  mul_en,
    output logic [NUM_BITS-1:0]   mul_a,
    output logic [NUM_BITS-1:0]   mul_b,
    output logic [NUM_BITS-1:0]   mul_c,
    output logic [NUM_BITS-1:0]   mul_d,
    input  logic [4*NUM_BITS-1:0] mul_z,
    input  logic                  mul_ov
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_accept;
    logic                    w_any_zero;
    logic [4*NUM_BITS-1:0]   r_z;
    logic [NUM_BITS-1:0]     r_mul_a;
    logic [NUM_BITS-1:0]     r_mul_b;
    logic [NUM_BITS-1:0]     r_mul_c;
    logic [NUM_BITS-1:0]     r_mul_d;

    assign w_accept   = in_valid && in_ready;
    assign w_any_zero = (in_a == '0) || (in_b == '0) || (in_c == '0) || (in_d == '0);

    // Next state and state-decoded outputs. mul_ov only matters in RUN.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        mul_rst   = 1'b0;
        mul_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = !rst;
                busy     = 1'b0;
                mul_rst  = 1'b1;
                if (w_accept)
                    w_next = w_any_zero ? ST_DONE : ST_CLEAR;
            end
            ST_CLEAR: begin
                mul_rst = 1'b1;
                w_next  = ST_RUN;
            end
            ST_RUN: begin
                mul_en = 1'b1;
                if (mul_ov)
                    w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_z     <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_mul_c <= '0;
            r_mul_d <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mul_a <= in_a;
                r_mul_b <= in_b;
                r_mul_c <= in_c;
                r_mul_d <= in_d;
                // Zero-operand jobs go straight to DONE with this value.
                r_z     <= '0;
            end
            if (r_state == ST_SETTLE)
                r_z <= mul_z;
        end
    end

    assign out_z = r_z;
    assign mul_a = r_mul_a;
    assign mul_b = r_mul_b;
    assign mul_c = r_mul_c;
    assign mul_d = r_mul_d;

`ifdef CYCLE_COUNT_EN
    logic [CNT_WIDTH-1:0] r_cycles;

    // Counts RUN cycles of the current job, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            r_cycles <= '0;
        else if (w_accept)
            r_cycles <= '0;
        else if ((r_state == ST_RUN) && (r_cycles != '1))
            r_cycles <= r_cycles + CNT_WIDTH'(1);
    end

    assign out_cycles = r_cycles;
`endif

endmodule
`default_nettype wire
